// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: stage occupancy states and the MEM2 stage bundle whose width sizes DATA_W.
// No logic; the helper maps a stage state to its entry count.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_OVERFLOW = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } RegsWrType;

    typedef struct packed {
        logic        en;
        logic        is_signed;
        logic [1:0]  size;
        logic [1:0]  byte_off;
        logic [31:0] addr;
    } LoadType;

    typedef struct packed {
        RegsWrType   regs_wr;
        LoadType     load;
        logic [31:0] pc;
        logic        exc_valid;
        logic [3:0]  exc_cause;
        logic [14:0] rob_tag;
    } Mem2StageType;

    localparam int MEM2_STAGE_W = $bits(Mem2StageType);

    function automatic logic [1:0] occ_of_state(input stage_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_FULL:     occ = 2'd1;
            ST_OVERFLOW: occ = 2'd2;
            default:     occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/mem_pipe_stage_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Latency: count visible one cycle after the event; no backpressure.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sat_counter: CNT_W must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_pipe_stage.sv
// Valid/ready pipeline register between MEM/MEM2/WB, optional 2-entry skid, flush, stall counter.
// Latency 1 cycle; SKID=0 passes out_ready through to in_ready, SKID=1 registers in_ready.
module mem_pipe_stage
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W        = MEM2_STAGE_W,
    parameter int SKID          = 1,
    parameter int ZERO_ON_FLUSH = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("mem_pipe_stage: DATA_W must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mem_pipe_stage: CNT_W must be at least 1");
    end
    if ((SKID != 0) && (SKID != 1)) begin : g_bad_skid
        $error("mem_pipe_stage: SKID must be 0 or 1");
    end

    stage_state_e      state;
    stage_state_e      state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              rdy_q;
    logic              accept;
    logic              emit;
    logic              main_ld;
    logic              main_from_skid;
    logic              skid_ld;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_data;
    assign occupancy = occ_of_state(state);
    assign in_ready  = (SKID == 1) ? rdy_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_FULL;
                    main_ld   = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && emit) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    // Only reachable with a skid entry: in_ready is registered and stayed high.
                    if (SKID == 1) begin
                        state_nxt = ST_OVERFLOW;
                        skid_ld   = 1'b1;
                    end
                end else if (emit) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_OVERFLOW: begin
                if (emit) begin
                    state_nxt      = ST_FULL;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            rdy_q     <= 1'b1;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
            rdy_q <= 1'b1;
            if (ZERO_ON_FLUSH != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != ST_OVERFLOW);
            if (main_ld) begin
                main_data <= in_data;
            end else if (main_from_skid) begin
                main_data <= skid_data;
            end
            if (skid_ld) begin
                skid_data <= in_data;
            end
        end
    end

    // Flush deliberately does not touch the counter: it measures stalls, not entries.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .clr (stall_clr),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_mem_pipe_stage.sv
// Directed bench: table-driven vectors on a SKID=1 stage, hand sequences for
// saturation, reset-in-overflow, SKID=0 zero-bubble and ZERO_ON_FLUSH=0 flush.
module tb_mem_pipe_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // d1: SKID=1, ZERO_ON_FLUSH=1, CNT_W=4
    logic       fl1, iv1, or1, cl1, ov1, ir1;
    logic [7:0] id1, od1;
    logic [1:0] oc1;
    logic [3:0] sc1;
    // d0: SKID=0, ZERO_ON_FLUSH=1, CNT_W=16
    logic        fl0, iv0, or0, cl0, ov0, ir0;
    logic [7:0]  id0, od0;
    logic [1:0]  oc0;
    logic [15:0] sc0;
    // dz: SKID=1, ZERO_ON_FLUSH=0, CNT_W=8
    logic       flz, ivz, orz, clz, ovz, irz;
    logic [7:0] idz, odz;
    logic [1:0] ocz;
    logic [7:0] scz;

    mem_pipe_stage #(.DATA_W(8), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(4)) u_d1 (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1),
        .stall_cnt(sc1), .stall_clr(cl1));

    mem_pipe_stage #(.DATA_W(8), .SKID(0), .ZERO_ON_FLUSH(1), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(oc0),
        .stall_cnt(sc0), .stall_clr(cl0));

    mem_pipe_stage #(.DATA_W(8), .SKID(1), .ZERO_ON_FLUSH(0), .CNT_W(8)) u_dz (
        .clk(clk), .rst(rst), .flush(flz), .in_valid(ivz), .in_ready(irz), .in_data(idz),
        .out_valid(ovz), .out_ready(orz), .out_data(odz), .occupancy(ocz),
        .stall_cnt(scz), .stall_clr(clz));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst, fl, iv;
        logic [7:0] id;
        logic       ordy, clr;
        logic       ov, ir;
        logic [7:0] od;
        logic [1:0] occ;
        logic [3:0] sc;
    } vec_t;

    vec_t vt[32];
    int   nv;

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [7:0] d,
                                input logic o, input logic c, input logic eov, input logic eir,
                                input logic [7:0] eod, input logic [1:0] eocc, input logic [3:0] esc);
        vec_t t;
        t.rst = r;  t.fl = f;  t.iv = v;  t.id = d;  t.ordy = o;  t.clr = c;
        t.ov = eov; t.ir = eir; t.od = eod; t.occ = eocc; t.sc = esc;
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        {fl1, iv1, or1, cl1, id1} = '0;
        {fl0, iv0, or0, cl0, id0} = '0;
        {flz, ivz, orz, clz, idz} = '0;

        //          rst fl iv  id    ordy clr | ov ir  od    occ sc
        nv = 0;
        vt[nv++] = mk(1, 0, 0, 8'h00, 0, 0,   0, 1, 8'h00, 0, 0);  // reset
        vt[nv++] = mk(0, 0, 1, 8'h01, 1, 0,   1, 1, 8'h01, 1, 0);  // stream 1..4
        vt[nv++] = mk(0, 0, 1, 8'h02, 1, 0,   1, 1, 8'h02, 1, 0);
        vt[nv++] = mk(0, 0, 1, 8'h03, 1, 0,   1, 1, 8'h03, 1, 0);
        vt[nv++] = mk(0, 0, 1, 8'h04, 1, 0,   1, 1, 8'h04, 1, 0);
        vt[nv++] = mk(0, 0, 0, 8'h00, 1, 0,   0, 1, 8'h04, 0, 0);  // drain
        vt[nv++] = mk(0, 0, 1, 8'h0A, 0, 0,   1, 1, 8'h0A, 1, 0);  // A held
        vt[nv++] = mk(0, 0, 1, 8'h0B, 0, 0,   1, 0, 8'h0A, 2, 1);  // B into skid
        vt[nv++] = mk(0, 0, 1, 8'h0C, 0, 0,   1, 0, 8'h0A, 2, 2);  // C refused
        vt[nv++] = mk(0, 0, 0, 8'h00, 1, 0,   1, 1, 8'h0B, 1, 2);  // A out, B to main
        vt[nv++] = mk(0, 0, 0, 8'h00, 1, 0,   0, 1, 8'h0B, 0, 2);  // B out
        vt[nv++] = mk(0, 0, 1, 8'h11, 0, 0,   1, 1, 8'h11, 1, 2);
        vt[nv++] = mk(0, 0, 1, 8'h22, 0, 0,   1, 0, 8'h11, 2, 3);  // overflow
        vt[nv++] = mk(0, 1, 1, 8'h33, 0, 0,   0, 1, 8'h00, 0, 4);  // flush + in_valid
        vt[nv++] = mk(0, 0, 0, 8'h00, 1, 0,   0, 1, 8'h00, 0, 4);  // flushed entry stays dead
        vt[nv++] = mk(0, 0, 0, 8'h00, 1, 1,   0, 1, 8'h00, 0, 0);  // stall_clr

        for (int i = 0; i < nv; i++) begin
            rst = vt[i].rst; fl1 = vt[i].fl; iv1 = vt[i].iv; id1 = vt[i].id;
            or1 = vt[i].ordy; cl1 = vt[i].clr;
            tick();
            chk($sformatf("v%0d out_valid", i), ov1, vt[i].ov);
            chk($sformatf("v%0d in_ready", i), ir1, vt[i].ir);
            chk($sformatf("v%0d out_data", i), od1, vt[i].od);
            chk($sformatf("v%0d occupancy", i), oc1, vt[i].occ);
            chk($sformatf("v%0d stall_cnt", i), sc1, vt[i].sc);
        end
        {fl1, iv1, or1, cl1, id1} = '0;

        chk("d0 reset out_valid", ov0, 0);
        chk("d0 reset in_ready", ir0, 1);
        chk("dz reset out_valid", ovz, 0);
        chk("dz reset in_ready", irz, 1);

        // Saturation at 15 with out_data stable while stalled.
        iv1 = 1; id1 = 8'h5A; or1 = 0;
        tick();
        chk("sat load out_valid", ov1, 1);
        chk("sat load stall_cnt", sc1, 0);
        iv1 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat hold%0d out_data", k), od1, 8'h5A);
            if (k == 14) chk("sat stall_cnt at 14", sc1, 14);
        end
        chk("sat stall_cnt saturated", sc1, 15);
        cl1 = 1;
        tick();
        chk("clr wins over stall", sc1, 0);
        cl1 = 0;
        tick();
        chk("count resumes after clr", sc1, 1);

        // Reset while in OVERFLOW with stall_cnt=7.
        iv1 = 1; id1 = 8'h6B;
        tick();
        iv1 = 0;
        chk("rst-seq occupancy", oc1, 2);
        chk("rst-seq in_ready", ir1, 0);
        repeat (5) tick();
        chk("rst-seq stall_cnt", sc1, 7);
        chk("rst-seq out_data", od1, 8'h5A);
        rst = 1;
        tick();
        rst = 0;
        chk("post-rst out_valid", ov1, 0);
        chk("post-rst in_ready", ir1, 1);
        chk("post-rst out_data", od1, 0);
        chk("post-rst occupancy", oc1, 0);
        chk("post-rst stall_cnt", sc1, 0);

        // SKID=0: combinational in_ready, zero-bubble replace.
        iv0 = 1; id0 = 8'h05; or0 = 0;
        #1;
        chk("d0 empty in_ready", ir0, 1);
        tick();
        chk("d0 full out_valid", ov0, 1);
        chk("d0 full out_data", od0, 8'h05);
        chk("d0 full occupancy", oc0, 1);
        id0 = 8'h06;
        #1;
        chk("d0 full blocked in_ready", ir0, 0);
        or0 = 1;
        #1;
        chk("d0 comb in_ready", ir0, 1);
        tick();
        chk("d0 no-bubble out_valid", ov0, 1);
        chk("d0 no-bubble out_data", od0, 8'h06);
        chk("d0 stall_cnt", sc0, 0);
        iv0 = 0;
        tick();
        chk("d0 drain out_valid", ov0, 0);
        chk("d0 drain occupancy", oc0, 0);

        // ZERO_ON_FLUSH=0: flush in OVERFLOW keeps payload.
        ivz = 1; idz = 8'h11; orz = 0;
        tick();
        idz = 8'h22;
        tick();
        chk("dz overflow occupancy", ocz, 2);
        chk("dz overflow in_ready", irz, 0);
        flz = 1; idz = 8'h33;
        tick();
        flz = 0; ivz = 0;
        chk("dz flush out_valid", ovz, 0);
        chk("dz flush occupancy", ocz, 0);
        chk("dz flush in_ready", irz, 1);
        chk("dz flush payload held", odz, 8'h11);
        chk("dz flush stall_cnt", scz, 2);
        ivz = 1; idz = 8'h44; orz = 1;
        tick();
        ivz = 0;
        chk("dz refill out_valid", ovz, 1);
        chk("dz refill out_data", odz, 8'h44);
        tick();
        chk("dz refill drain", ovz, 0);
        chk("dz stall_cnt final", scz, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_pipe_stage.md
Name: mem_pipe_stage

Overview:
- Parametrised pipeline-stage register that replaces the fixed-field, write-enable-style stage registers between MEM, MEM2 and WB.
- Carries an opaque packed payload using a valid/ready handshake. It has an optional 2-entry skid mode that breaks the combinational ready path, and a flush that kills all in-flight entries.
- Also provides a saturating back-pressure cycle counter for performance debug.

Parameters:
- DATA_W, 128: payload width in bits (the packed stage bundle).
- SKID, 1: 0 = single entry, in_ready combinational from out_ready; 1 = two entries (main + skid), in_ready registered.
- ZERO_ON_FLUSH, 1: 1 = payload registers cleared to 0 on reset/flush; 0 = payload held, only valid bits cleared.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill all entries (exception/branch-mispredict redirect).
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload to downstream.
- occupancy  out  2  number of valid entries held (0..2; 0..1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  in  1  clear stall_cnt synchronously.

Behaviour:
- Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- Reset (rst=1 at edge):
  - all valid bits are 0; out_valid=0; occupancy=0; stall_cnt=0.
  - payload registers are 0 (regardless of ZERO_ON_FLUSH).
  - in_ready after reset is 1.
- Priority per edge: rst > flush > normal operation.
- Flush:
  - Clears all valid bits; stall_cnt is unchanged.
  - Any accept in the flush cycle is discarded; upstream is responsible for also flushing.
  - Payload is zeroed only if ZERO_ON_FLUSH=1.
  - out_valid=0 on the cycle after flush.
- SKID=0:
  - States: EMPTY, FULL.
  - in_ready = !out_valid | out_ready (combinational).
  - EMPTY + accept -> FULL.
  - FULL + emit + accept -> FULL with new data (zero-bubble).
  - FULL + emit, no accept -> EMPTY.
  - FULL, no emit -> hold.
- SKID=1:
  - States: EMPTY, FULL, OVERFLOW (main + skid both valid).
  - in_ready = !skid_valid, driven directly from a flop.
  - EMPTY + accept -> FULL, main <= in_data.
  - FULL + accept + emit -> FULL, main <= in_data.
  - FULL + accept, no emit -> OVERFLOW, skid <= in_data.
  - FULL + emit, no accept -> EMPTY.
  - OVERFLOW + emit -> FULL, main <= skid. No accept is possible in OVERFLOW because in_ready=0.
  - OVERFLOW, no emit -> hold.
  - out_data always comes from main. Ordering is strictly FIFO; no entry is lost or duplicated.
- Latency: 1 cycle from accept to out_valid in either mode. Throughput is 1/cycle when out_ready is held at 1.
- occupancy: EMPTY=0, FULL=1, OVERFLOW=2.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - stall_clr sets it to 0; stall_clr wins over increment in the same cycle.
  - Not cleared by flush.
- in_valid is sampled only when in_ready=1. Upstream must not be required to hold data when in_ready=0.
- Illegal: DATA_W<1 or CNT_W<1 must fail elaboration. SKID values other than 0 or 1 must fail elaboration.

Decomposition:
- Shared package (cpu_pipe_pkg): stage state enum {ST_EMPTY, ST_FULL, ST_OVERFLOW}.
- Existing stage bundle typedefs (RegsWrType, LoadType and the MEM2 payload struct) are packed by the instantiating stage. Their total width is exported from the package as a localparam for DATA_W.
- One natural sub-module: sat_counter (CNT_W, inc, clr -> cnt), reused by other perf counters.

Test Plan:
- Reset, then SKID=1, out_ready=1, stream in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each; in_ready stays 1; stall_cnt=0.
- SKID=1, send 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0. Raise out_ready -> 0xA, then 0xB, occupancy 2->1->0; stall_cnt equals the number of held cycles.
- SKID=0, FULL with 0x5, out_ready=1 and in_valid=1 with 0x6 in the same cycle -> in_ready=1 combinationally; next cycle out_data=0x6, no bubble.
- In OVERFLOW, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1. Payload reads 0 when ZERO_ON_FLUSH=1 and holds its old value when ZERO_ON_FLUSH=0.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15. stall_clr with a stall in the same cycle -> 0.
- Assert rst while in OVERFLOW with stall_cnt=7 -> next cycle all outputs 0 except in_ready=1; stall_cnt=0.
